// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GF(2^128) constants and multiplier FSM encoding
package gcm_pkg;
    localparam int GF_W = 128;
    localparam logic [GF_W-1:0] GF_R = 128'hE1000000_00000000_00000000_00000000;
    typedef enum logic [1:0] {
        GF_IDLE = 2'd0,
        GF_BUSY = 2'd1,
        GF_DONE = 2'd2
    } gf_state_t;
endpackage

// File: rtl/gf128_step.sv
// gf128_step: one MSB-first bit step of the GCM right-shift multiplier
module gf128_step
    import gcm_pkg::*;
(
    input  logic [GF_W-1:0] z,
    input  logic [GF_W-1:0] v,
    input  logic            xbit,
    output logic [GF_W-1:0] z_nxt,
    output logic [GF_W-1:0] v_nxt
);
    assign z_nxt = xbit ? z ^ v : z;
    assign v_nxt = v[0] ? (v >> 1) ^ GF_R : v >> 1;
endmodule

// File: rtl/gf128_mult.sv
// gf128_mult: digit-serial GF(2^128) multiplier for the GHASH path
module gf128_mult
    import gcm_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_GF,
    input  logic [GF_W-1:0] x_in,
    input  logic [GF_W-1:0] h_in,
    output logic [GF_W-1:0] z_out,
    output logic            done_GF,
    output logic            busy
);
    localparam int NSTEP = GF_W / DIGIT;
    localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (DIGIT != 1 && DIGIT != 2 && DIGIT != 4 && DIGIT != 8 && DIGIT != 16) begin : g_bad_digit
        $error("gf128_mult: DIGIT must be 1, 2, 4, 8 or 16");
    end

    gf_state_t       state;
    gf_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [GF_W-1:0] xs;
    logic [GF_W-1:0] v;
    logic [GF_W-1:0] z;
    logic [GF_W-1:0] zc [DIGIT+1];
    logic [GF_W-1:0] vc [DIGIT+1];
    logic            last;

    assign last    = cnt == CW'(NSTEP - 1);
    assign busy    = state == GF_BUSY;
    assign done_GF = state == GF_DONE;
    assign zc[0]   = z;
    assign vc[0]   = v;

    for (genvar i = 0; i < DIGIT; i++) begin : g_step
        gf128_step u_step (
            .z     (zc[i]),
            .v     (vc[i]),
            .xbit  (xs[GF_W-1-i]),
            .z_nxt (zc[i+1]),
            .v_nxt (vc[i+1])
        );
    end

    // next state: start on request, finish after NSTEP digits, hold result while requested
    always_comb begin
        state_nxt = (state == GF_IDLE) ? (en_GF ? GF_BUSY : GF_IDLE) :
                    (state == GF_BUSY) ? (last ? GF_DONE : GF_BUSY) :
                    (en_GF ? GF_DONE : GF_IDLE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= GF_IDLE;
        else     state <= state_nxt;
    end

    // operand capture, digit-serial accumulation and result publish
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            xs    <= '0;
            v     <= '0;
            z     <= '0;
            z_out <= '0;
        end else if (state == GF_IDLE && en_GF) begin
            cnt <= '0;
            xs  <= x_in;
            v   <= h_in;
            z   <= '0;
        end else if (state == GF_BUSY) begin
            cnt <= cnt + CW'(1);
            xs  <= xs << DIGIT;
            v   <= vc[DIGIT];
            z   <= zc[DIGIT];
            if (last) z_out <= zc[DIGIT];
        end
    end
endmodule
